// File: rtl/keypad_scan_ctrl.sv
// Row-scanning sequencer for a 4x4 keypad: one-hot row drive, column synchroniser,
// single-key debounce with N-key lockout, and a one-cycle strobe per accepted press.
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_SCAN     | rotate rows, sample columns on the last dwell cycle
// ST_DEBOUNCE | row frozen, candidate column must stay stable
// ST_HELD     | key accepted, other keys locked out until all columns idle
// ST_RELEASE  | columns idle, must stay idle before scanning resumes
module keypad_scan_ctrl #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [3:0] key_r,
  output logic [3:0] key_c,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    cols_meta;
  logic [3:0]    cols_s;
  logic [3:0]    cand_c;

  logic [3:0] low_n;
  logic       single_press;
  logic       cols_idle;
  logic       scan_last;
  logic       deb_last;
  logic [3:0] rows_next;

  // Exactly one active-low column: the inverted vector is a non-zero power of two.
  always_comb begin
    low_n        = ~cols_s;
    single_press = (low_n != 4'b0000) && ((low_n & (low_n - 4'd1)) == 4'b0000);
    cols_idle    = (cols_s == 4'b1111);
    scan_last    = (cnt == CW'(SCAN_CYCLES - 1));
    deb_last     = (cnt == CW'(DEBOUNCE_CYCLES - 1));
    rows_next    = {rows[0], rows[3:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cols_meta <= 4'b1111;
      cols_s    <= 4'b1111;
      state     <= ST_SCAN;
      cnt       <= '0;
      cand_c    <= 4'b1111;
      rows      <= 4'b1000;
      key_r     <= 4'b0000;
      key_c     <= 4'b1111;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      cols_meta <= cols;
      cols_s    <= cols_meta;
      key_valid <= 1'b0;

      case (state)
        ST_SCAN: begin
          if (scan_last) begin
            cnt <= '0;
            if (single_press) begin
              cand_c <= cols_s;
              state  <= ST_DEBOUNCE;
            end else begin
              rows <= rows_next;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DEBOUNCE: begin
          if (cols_s != cand_c) begin
            state <= ST_SCAN;
            cnt   <= '0;
          end else if (deb_last) begin
            state     <= ST_HELD;
            cnt       <= '0;
            key_r     <= rows;
            key_c     <= cand_c;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        // Any non-idle pattern keeps the accepted key; extra keys are simply ignored.
        ST_HELD: begin
          if (cols_idle) begin
            state <= ST_RELEASE;
            cnt   <= '0;
          end
        end

        ST_RELEASE: begin
          if (!cols_idle) begin
            state <= ST_HELD;
            cnt   <= '0;
          end else if (deb_last) begin
            state    <= ST_SCAN;
            cnt      <= '0;
            key_held <= 1'b0;
            rows     <= rows_next;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state <= ST_SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad pin model, directed corner sequences,
// a table of press scenarios and a randomized run against a behavioural model.
module tb_keypad_scan_ctrl;

  localparam int SCAN = 4;
  localparam int DEB  = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cols;
  logic [3:0] rows;
  logic [3:0] key_r;
  logic [3:0] key_c;
  logic       key_valid;
  logic       key_held;

  // Keypad: the pressed pattern appears only while its row is driven.
  logic       p_on  = 1'b0;
  logic [3:0] p_row = 4'b1000;
  logic [3:0] p_col = 4'b1111;

  int n_cmp     = 0;
  int n_bad     = 0;
  int v_cnt     = 0;
  bit cmp_model = 1'b0;

  always #5 clk = ~clk;

  assign cols = (p_on && rows == p_row) ? p_col : 4'b1111;

  keypad_scan_ctrl #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .key_r     (key_r),
    .key_c     (key_c),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  localparam int M_SCAN    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_HOLD    = 2;
  localparam int M_LETGO   = 3;

  int         m_row;
  int         m_mode;
  int         m_cnt;
  logic [3:0] m_s1, m_s2, m_cand, m_kr, m_kc;
  logic       m_valid, m_held;

  task automatic model_reset();
    m_row = 0; m_mode = M_SCAN; m_cnt = 0;
    m_s1 = 4'hf; m_s2 = 4'hf; m_cand = 4'hf;
    m_kr = 4'h0; m_kc = 4'hf; m_valid = 1'b0; m_held = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] pin, s, mrows;
    mrows   = 4'b1000 >> m_row;
    pin     = (p_on && mrows == p_row) ? p_col : 4'hf;
    s       = m_s2;
    m_s2    = m_s1;
    m_s1    = pin;
    m_valid = 1'b0;
    case (m_mode)
      M_SCAN:
        if (m_cnt == SCAN - 1) begin
          m_cnt = 0;
          if ($countones(~s) == 1) begin m_cand = s; m_mode = M_CONFIRM; end
          else m_row = (m_row + 1) % 4;
        end else m_cnt++;
      M_CONFIRM:
        if (s != m_cand) begin m_mode = M_SCAN; m_cnt = 0; end
        else if (m_cnt == DEB - 1) begin
          m_mode = M_HOLD; m_cnt = 0; m_kr = mrows; m_kc = m_cand;
          m_valid = 1'b1; m_held = 1'b1;
        end else m_cnt++;
      M_HOLD:
        if (s == 4'hf) begin m_mode = M_LETGO; m_cnt = 0; end
      default:
        if (s != 4'hf) begin m_mode = M_HOLD; m_cnt = 0; end
        else if (m_cnt == DEB - 1) begin
          m_mode = M_SCAN; m_cnt = 0; m_held = 1'b0; m_row = (m_row + 1) % 4;
        end else m_cnt++;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Keypad legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D  (* = E, # = F)
  function automatic logic [3:0] decode(input logic [3:0] kr, input logic [3:0] kc);
    logic [3:0] map [4][4];
    int r, c;
    map = '{'{4'd1, 4'd2, 4'd3, 4'd10}, '{4'd4, 4'd5, 4'd6, 4'd11},
            '{4'd7, 4'd8, 4'd9, 4'd12}, '{4'd14, 4'd0, 4'd15, 4'd13}};
    r = kr[3] ? 0 : kr[2] ? 1 : kr[1] ? 2 : 3;
    c = !kc[0] ? 0 : !kc[1] ? 1 : !kc[2] ? 2 : 3;
    return map[r][c];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
    if (key_valid) v_cnt++;
    if (cmp_model)
      check("model", {rows, key_r, key_c, key_valid, key_held},
            {4'b1000 >> m_row, m_kr, m_kc, m_valid, m_held});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_held(input logic lvl, input int limit, input string name);
    int i = 0;
    while (key_held !== lvl && i < limit) begin tick(); i++; end
    check(name, key_held, lvl);
  endtask

  task automatic wait_valid(input int limit, input string name);
    int i = 0;
    v_cnt = 0;
    while (v_cnt == 0 && i < limit) begin tick(); i++; end
    check(name, v_cnt, 1);
  endtask

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    int         n_valid;
    logic [3:0] exp_r;
    logic [3:0] exp_c;
    logic [3:0] exp_dec;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, rot;
    bit bad;
    logic [3:0] prev;

    vecs[0] = '{4'b0100, 4'b1011, 1, 4'b0100, 4'b1011, 4'd6};
    vecs[1] = '{4'b1000, 4'b1110, 1, 4'b1000, 4'b1110, 4'd1};
    vecs[2] = '{4'b0010, 4'b1101, 1, 4'b0010, 4'b1101, 4'd8};
    vecs[3] = '{4'b0001, 4'b0111, 1, 4'b0001, 4'b0111, 4'd13};
    vecs[4] = '{4'b0001, 4'b0110, 0, 4'b0001, 4'b0111, 4'd13};
    vecs[5] = '{4'b1000, 4'b1100, 0, 4'b0001, 4'b0111, 4'd13};

    // 1: reset values and idle row rotation
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_rows", rows, 4'b1000);
    check("rst_key_r", key_r, 4'b0000);
    check("rst_key_c", key_c, 4'b1111);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    reset = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      tick();
      check("idle_rows", rows, 4'b1000 >> ((j / SCAN) % 4));
    end

    // 2: clean press row 2 / col 3, held 60 cycles
    p_row = 4'b0100; p_col = 4'b1011; p_on = 1'b1;
    wait_valid(40, "t2_valid_seen");
    bad = 1'b0;
    repeat (60) begin
      tick();
      if (rows !== 4'b0100 || key_held !== 1'b1) bad = 1'b1;
    end
    check("t2_valid_count", v_cnt, 1);
    check("t2_frozen_held", bad, 1'b0);
    check("t2_key_r", key_r, 4'b0100);
    check("t2_key_c", key_c, 4'b1011);
    check("t2_decode", decode(key_r, key_c), 4'd6);

    // 4: release bounce from the held key
    p_on = 1'b0; repeat (5) tick();
    p_on = 1'b1; repeat (3) tick();
    p_on = 1'b0;
    n = 0;
    while (key_held === 1'b1 && n < 30) begin tick(); n++; end
    check("t4_no_second_valid", v_cnt, 1);
    check("t4_fall_window", (n >= DEB && n <= DEB + 3), 1'b1);
    check("t4_rows_after", rows, 4'b0010);

    // 3: bouncing press on row 1 / col 1
    do_reset();
    p_row = 4'b1000; p_col = 4'b1110; v_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      p_on = ((i / 2) % 2 == 0);
      tick();
    end
    p_on = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (rows === 4'b0100) bad = 1'b1;
    end
    check("t3_no_valid", v_cnt, 0);
    check("t3_not_held", key_held, 1'b0);
    check("t3_scan_resumed", bad, 1'b1);

    // 5: two keys on row 4, then N-key lockout
    p_row = 4'b0001; p_col = 4'b0110; p_on = 1'b1; v_cnt = 0; rot = 0;
    prev = rows;
    repeat (40) begin
      tick();
      if (rows !== prev) rot++;
      prev = rows;
    end
    check("t5_multi_no_valid", v_cnt, 0);
    check("t5_multi_rotates", (rot >= 8), 1'b1);
    p_col = 4'b0111;
    wait_valid(40, "t5_single_valid");
    check("t5_key_r", key_r, 4'b0001);
    check("t5_key_c", key_c, 4'b0111);
    check("t5_decode", decode(key_r, key_c), 4'd13);
    p_col = 4'b0110; v_cnt = 0;
    repeat (30) tick();
    check("t5_lockout_valid", v_cnt, 0);
    check("t5_lockout_key_c", key_c, 4'b0111);
    check("t5_lockout_held", key_held, 1'b1);
    p_on = 1'b0;
    wait_held(1'b0, 40, "t5_release");

    // 6: reset during HELD
    p_row = 4'b1000; p_col = 4'b1110; p_on = 1'b1;
    wait_held(1'b1, 40, "t6_reach_held");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    check("t6_rows", rows, 4'b1000);
    check("t6_held", key_held, 1'b0);
    check("t6_key_r", key_r, 4'b0000);
    check("t6_key_c", key_c, 4'b1111);
    p_on = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    v_cnt = 0;
    repeat (8) tick();
    check("t6_no_valid_after", v_cnt, 0);

    // Table of press scenarios
    for (int k = 0; k < 6; k++) begin
      p_row = vecs[k].row; p_col = vecs[k].col; p_on = 1'b1; v_cnt = 0;
      repeat (50) tick();
      check($sformatf("vec%0d_valid_count", k), v_cnt, vecs[k].n_valid);
      check($sformatf("vec%0d_key_r", k), key_r, vecs[k].exp_r);
      check($sformatf("vec%0d_key_c", k), key_c, vecs[k].exp_c);
      check($sformatf("vec%0d_decode", k), decode(key_r, key_c), vecs[k].exp_dec);
      p_on = 1'b0;
      wait_held(1'b0, 40, $sformatf("vec%0d_release", k));
    end

    // Randomized presses against the behavioural model
    do_reset();
    cmp_model = 1'b1;
    for (int it = 0; it < 25; it++) begin
      int c, hold, idle;
      bit bounce;
      c      = $urandom_range(0, 3);
      p_row  = 4'b1000 >> $urandom_range(0, 3);
      p_col  = ~(4'b0001 << c);
      if ($urandom_range(0, 4) == 0) p_col = p_col & ~(4'b0001 << $urandom_range(0, 3));
      bounce = ($urandom_range(0, 3) == 0);
      hold   = $urandom_range(5, 45);
      idle   = $urandom_range(3, 30);
      for (int j = 0; j < hold; j++) begin
        p_on = (bounce && j < 6) ? j[0] : 1'b1;
        tick();
      end
      p_on = 1'b0;
      repeat (idle) tick();
    end
    cmp_model = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
